rom_select: RTL and testbench

ROM_SELECT -- requirements
Module: rom_select

---
 rtl/nes_ctrl_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 79 +++++++
 rtl/rom_select.sv | 164 ++++++++++++++++
 tb/tb_rom_select.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_ctrl_pkg.sv
// nes_ctrl_pkg
// Shared definitions for the ROM-select controller:
//   - state_e         : FSM state encoding for rom_select
//   - WAIT_LOW_CYCLES : how long to wait for the loader to drop load_done
//   - next_index()    : ROM index increment with wrap at the ROM count
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_PULSE     = 3'd3,
    ST_WAIT_LOW  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  // Cycles spent in WAIT_LOW before assuming the loader missed the request.
  localparam int unsigned WAIT_LOW_CYCLES = 16;
  localparam int unsigned WAIT_CNT_W      = $clog2(WAIT_LOW_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LOW_CYCLES - 1);

  // Next ROM image number; wraps to 0 after num_roms-1, pinned at 0 for one ROM.
  function automatic logic [3:0] next_index(input logic [3:0] idx,
                                            input int unsigned num_roms);
    logic [3:0] nxt;
    if (num_roms <= 32'd1) begin
      nxt = 4'd0;
    end else if ({28'd0, idx} >= (num_roms - 32'd1)) begin
      nxt = 4'd0;
    end else begin
      nxt = idx + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a consecutive-cycle debouncer for an
// active-low push button.
// Ports:
//   clock  : system clock (rising edge)
//   reset  : asynchronous active-high reset
//   din_n  : raw active-low button, asynchronous to clock
//   level  : debounced level (1 = released), resets to 1
//   rise   : one-cycle pulse coincident with level changing 0 -> 1 (release)
//   fall   : one-cycle pulse coincident with level changing 1 -> 0 (press)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic din_n,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state logic: count cycles where the synchronized input disagrees
  // with the debounced level; any agreement restarts the count.
  always_comb begin
    sync1_d = din_n;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        // Last required disagreeing cycle: accept the new level now.
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; synchronizer and level idle high (button released).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/rom_select.sv
// rom_select
// Single-button ROM image selector. A short press advances to the next image,
// a long press reloads the current one. Each selection produces one reload
// pulse, after which the block stays busy until the loader reports done and
// the button is released.
// Ports:
//   clock     : system clock (rising edge)
//   reset     : asynchronous active-high reset
//   btn_n     : raw active-low select button, asynchronous
//   load_done : loader has finished the current image
//   reload    : one-cycle request to load image `index`
//   index     : currently selected ROM image
//   busy      : high from the reload pulse until the load completes
module rom_select
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 65536,
  parameter int unsigned LONG_PRESS_CYCLES = 16777216,
  parameter int unsigned NUM_ROMS          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       load_done,
  output logic       reload,
  output logic [3:0] index,
  output logic       busy
);

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  logic level_s;
  logic rise_s;
  logic fall_s;
  logic short_press_s;

  state_e                state_q,    state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]            index_q,    index_d;
  logic                  reload_q,   reload_d;
  logic                  busy_q,     busy_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock(clock),
    .reset(reset),
    .din_n(btn_n),
    .level(level_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Release before the hold threshold is a short press (advance index).
  always_comb begin
    short_press_s = 1'b0;
    if ((state_q == ST_PRESSED) && rise_s && (hold_cnt_q < HOLD_MAX)) begin
      short_press_s = 1'b1;
    end else begin
      short_press_s = 1'b0;
    end
  end

  // Next-state logic. Presses are only seen in IDLE, so presses while busy
  // are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) state_d = ST_PRESSED;
        else        state_d = ST_IDLE;
      end
      ST_PRESSED: begin
        if (short_press_s)               state_d = ST_PULSE;
        else if (hold_cnt_q == HOLD_MAX) state_d = ST_PULSE;
        else                             state_d = ST_PRESSED;
      end
      ST_PULSE: begin
        if (level_s) state_d = ST_WAIT_LOW;
        else         state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD: begin
        if (level_s) state_d = ST_WAIT_LOW;
        else         state_d = ST_LONG_HELD;
      end
      ST_WAIT_LOW: begin
        // Leave on the loader's acknowledge, or give up after the timeout.
        if (!load_done || (wait_cnt_q == WAIT_LAST)) state_d = ST_WAIT_DONE;
        else                                          state_d = ST_WAIT_LOW;
      end
      ST_WAIT_DONE: begin
        if (load_done && level_s) state_d = ST_IDLE;
        else                      state_d = ST_WAIT_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and counter logic. Outputs are decoded from the next state so the
  // registered reload/busy line up with the state they describe.
  always_comb begin
    index_d    = index_q;
    reload_d   = 1'b0;
    busy_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = '0;

    if (short_press_s) begin
      index_d = next_index(index_q, NUM_ROMS);
    end else begin
      index_d = index_q;
    end

    reload_d = (state_d == ST_PULSE);
    busy_d   = !((state_d == ST_IDLE) || (state_d == ST_PRESSED));

    if (state_q == ST_IDLE) begin
      hold_cnt_d = '0;
    end else if ((state_q == ST_PRESSED) && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    if (state_q == ST_WAIT_LOW) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= '0;
      wait_cnt_q <= '0;
      index_q    <= 4'd0;
      reload_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      index_q    <= index_d;
      reload_q   <= reload_d;
      busy_q     <= busy_d;
    end
  end

  assign reload = reload_q;
  assign index  = index_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rom_select.sv
// tb_rom_select
// Directed self-checking bench for rom_select with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=32, NUM_ROMS=3. Inputs change on the falling edge;
// outputs are sampled on the falling edge.
module tb_rom_select;

  logic       clock;
  logic       reset;
  logic       btn_n;
  logic       load_done;
  logic       reload;
  logic [3:0] index;
  logic       busy;

  int n_checks;
  int n_fail;
  int reload_count;

  rom_select #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(32),
    .NUM_ROMS         (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_n    (btn_n),
    .load_done(load_done),
    .reload   (reload),
    .index    (index),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every reload cycle seen on the sampling edge.
  always @(negedge clock) begin
    if (reload === 1'b1) reload_count = reload_count + 1;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    btn_n = 1'b1;
    load_done = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Hold the button down for n cycles, then release (on a falling edge).
  task automatic press(input int n);
    btn_n = 1'b0;
    repeat (n) @(negedge clock);
    btn_n = 1'b1;
  endtask

  // Wait for reload; lat = falling edges waited, 0 if it never came.
  task automatic wait_reload(input int limit, output int lat);
    lat = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (reload === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Loader handshake: drop load_done for two cycles, then raise it.
  task automatic do_load();
    load_done = 1'b0;
    repeat (2) @(negedge clock);
    load_done = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_n = 1'b1;
    load_done = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (reload !== 1'b0) begin n_fail++; $display("FAIL reset_reload: got %b expected 0", reload); end
    n_checks++;
    if (index !== 4'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", index); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_short_press();
    int lat;
    int base;
    base = reload_count;
    press(10);
    wait_reload(20, lat);
    // 2 sync + 4 debounce cycles to see the release, then 1 cycle to reload.
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL short_latency: got %0d expected 7", lat); end
    n_checks++;
    if (index !== 4'd1) begin n_fail++; $display("FAIL short_index: got %0d expected 1", index); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy_rise: got %b expected 1", busy); end
    @(negedge clock);
    n_checks++;
    if (reload !== 1'b0) begin n_fail++; $display("FAIL short_one_cycle: got %b expected 0", reload); end
    load_done = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy_loading: got %b expected 1", busy); end
    load_done = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_fall: got %b expected 0", busy); end
    n_checks++;
    if ((reload_count - base) !== 1) begin n_fail++; $display("FAIL short_pulses: got %0d expected 1", reload_count - base); end
  endtask

  task automatic test_three_short();
    logic [3:0] exp_idx [3];
    int lat;
    int base;
    exp_idx[0] = 4'd1;
    exp_idx[1] = 4'd2;
    exp_idx[2] = 4'd0;
    do_reset();
    base = reload_count;
    for (int p = 0; p < 3; p++) begin
      press(10);
      wait_reload(20, lat);
      n_checks++;
      if (index !== exp_idx[p]) begin n_fail++; $display("FAIL seq_index_%0d: got %0d expected %0d", p, index, exp_idx[p]); end
      do_load();
      repeat (3) @(negedge clock);
    end
    n_checks++;
    if ((reload_count - base) !== 3) begin n_fail++; $display("FAIL seq_pulses: got %0d expected 3", reload_count - base); end
  endtask

  task automatic test_long_press();
    int first;
    int base;
    logic [3:0] idx_at;
    do_reset();
    base = reload_count;
    first = 0;
    idx_at = 4'hF;
    btn_n = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if ((reload === 1'b1) && (first == 0)) begin
        first = k;
        idx_at = index;
      end
    end
    btn_n = 1'b1;
    // Press seen after 6 cycles, PRESSED from 7, threshold 32 cycles later.
    n_checks++;
    if (first !== 40) begin n_fail++; $display("FAIL long_latency: got %0d expected 40", first); end
    n_checks++;
    if (idx_at !== 4'd0) begin n_fail++; $display("FAIL long_index: got %0d expected 0", idx_at); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL long_busy_held: got %b expected 1", busy); end
    repeat (50) @(negedge clock);
    n_checks++;
    if ((reload_count - base) !== 1) begin n_fail++; $display("FAIL long_pulses: got %0d expected 1", reload_count - base); end
    n_checks++;
    if (index !== 4'd0) begin n_fail++; $display("FAIL long_index_after: got %0d expected 0", index); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL long_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int lat;
    do_reset();
    press(10);
    wait_reload(20, lat);
    n_checks++;
    if (lat !== 7) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 7", lat); end
    // PULSE 1 + WAIT_LOW 16 + WAIT_DONE 1 cycles of busy.
    repeat (17) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_before: got %b expected 1", busy); end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_bounce();
    int lat;
    int base;
    do_reset();
    base = reload_count;
    for (int b = 1; b <= 3; b++) begin
      btn_n = 1'b0;
      repeat (b) @(negedge clock);
      btn_n = 1'b1;
      repeat (8) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    n_checks++;
    if ((reload_count - base) !== 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 0", reload_count - base); end
    n_checks++;
    if (index !== 4'd0) begin n_fail++; $display("FAIL bounce_index: got %0d expected 0", index); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bounce_busy: got %b expected 0", busy); end
    // Real press, then a full press/release while busy with load_done stuck high.
    press(10);
    wait_reload(20, lat);
    @(negedge clock);
    press(6);
    repeat (40) @(negedge clock);
    n_checks++;
    if ((reload_count - base) !== 1) begin n_fail++; $display("FAIL busy_press_pulses: got %0d expected 1", reload_count - base); end
    n_checks++;
    if (index !== 4'd1) begin n_fail++; $display("FAIL busy_press_index: got %0d expected 1", index); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_press_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int base;
    // Reset while PRESSED.
    do_reset();
    base = reload_count;
    btn_n = 1'b0;
    repeat (12) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({reload, index, busy} !== 6'd0) begin n_fail++; $display("FAIL rst_pressed_out: got %b/%0d/%b expected 0/0/0", reload, index, busy); end
    btn_n = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    n_checks++;
    if ((reload_count - base) !== 0) begin n_fail++; $display("FAIL rst_pressed_pulses: got %0d expected 0", reload_count - base); end
    // Reset while WAIT_DONE.
    press(10);
    wait_reload(20, lat);
    load_done = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({index, busy} !== 5'b0001_1) begin n_fail++; $display("FAIL wait_done_state: got %0d/%b expected 1/1", index, busy); end
    base = reload_count;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({reload, index, busy} !== 6'd0) begin n_fail++; $display("FAIL rst_wait_out: got %b/%0d/%b expected 0/0/0", reload, index, busy); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    load_done = 1'b1;
    repeat (40) @(negedge clock);
    n_checks++;
    if ((reload_count - base) !== 0) begin n_fail++; $display("FAIL rst_wait_pulses: got %0d expected 0", reload_count - base); end
    n_checks++;
    if ({index, busy} !== 5'd0) begin n_fail++; $display("FAIL rst_wait_after: got %0d/%b expected 0/0", index, busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reload_count = 0;
    reset = 1'b1;
    btn_n = 1'b1;
    load_done = 1'b1;
    test_reset();
    test_short_press();
    test_three_short();
    test_long_press();
    test_timeout();
    test_bounce();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
